// File: rtl/alu_decoder_pipe.sv
// alu_decoder_pipe
//   Elastic-pipelined RV32I ALU control decoder. The main-decoder fields are
//   decoded combinationally, captured into stage 0, and then walk through
//   DEPTH-1 further elastic registers to the execute stage. Undecodable
//   encodings come out as ALUControl=0 with illegal=1.
//
// Parameters
//   CTRL_W  ALUControl width (4 = full RV32I set, 3 = legacy subset)
//   DEPTH   pipeline stages, 1..4
//   CNT_W   illegal counter width
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        input handshake
//   ALUOp, funct3, op_5,
//   funct7_5                   main-decoder fields
//   out_valid / out_ready      output handshake
//   ALUControl, illegal        decoded word
//   clr_count, illegal_count   saturating count of delivered illegal words
//
// Build option
//   ALUDEC_ILLEGAL_CNT_EN  when defined, compiles in the illegal counter;
//                          otherwise illegal_count is 0 and clr_count ignored.
module alu_decoder_pipe #(
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic              op_5,
    input  logic              funct7_5,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              illegal,
    input  logic              clr_count,
    output logic [CNT_W-1:0]  illegal_count
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    // ---------------- decode ----------------
    logic [3:0]        op4;
    logic              dec_ill;
    logic [CTRL_W-1:0] dec_ctrl;

    always_comb begin
        op4     = OP_ADD;
        dec_ill = 1'b0;
        case (ALUOp)
            2'b00: op4 = OP_ADD;
            2'b01: op4 = OP_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  op4 = (op_5 & funct7_5) ? OP_SUB : OP_ADD;
                    3'b001:  op4 = OP_SLL;
                    3'b010:  op4 = OP_SLT;
                    3'b011:  op4 = OP_SLTU;
                    3'b100:  op4 = OP_XOR;
                    // shifts key off funct7_5 alone: srai/srli share it with R-type
                    3'b101:  op4 = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110:  op4 = OP_OR;
                    default: op4 = OP_AND;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // narrow control word only encodes add/sub/and/or/slt
        if (CTRL_W < 4 && !(op4 inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT}))
            dec_ill = 1'b1;
        dec_ctrl = dec_ill ? '0 : CTRL_W'(op4);
    end

    // ---------------- elastic pipeline ----------------
    // Index 0 of s_* is the decoded input; index i is the output of stage i-1.
    logic [DEPTH:1]             vld_pipe;
    logic [DEPTH:1][CTRL_W-1:0] ctrl_q;
    logic [DEPTH:1]             ill_q;
    logic [DEPTH:0]             s_vld;
    logic [DEPTH:0][CTRL_W-1:0] s_ctrl;
    logic [DEPTH:0]             s_ill;
    logic [DEPTH:0]             rdy;

    assign s_vld  = {vld_pipe, in_valid};
    assign s_ctrl = {ctrl_q, dec_ctrl};
    assign s_ill  = {ill_q, dec_ill};

    // A stage can take a word if it is empty or its word moves on this cycle.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--)
            rdy[i] = !vld_pipe[i+1] | rdy[i+1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            ctrl_q   <= '0;
            ill_q    <= '0;
        end else begin
            for (int i = 1; i <= DEPTH; i++) begin
                if (rdy[i-1]) begin
                    vld_pipe[i] <= s_vld[i-1];
                    // data only loads with a real word so a stalled output stays put
                    if (s_vld[i-1]) begin
                        ctrl_q[i] <= s_ctrl[i-1];
                        ill_q[i]  <= s_ill[i-1];
                    end
                end
            end
        end
    end

    assign in_ready   = rdy[0] & !reset;
    assign out_valid  = vld_pipe[DEPTH];
    assign ALUControl = ctrl_q[DEPTH];
    assign illegal    = ill_q[DEPTH];

    // ---------------- illegal counter ----------------
`ifdef ALUDEC_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (clr_count)
            cnt_q <= '0;
        else if (out_valid && out_ready && illegal && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign illegal_count = cnt_q;
`else
    logic unused_clr;
    assign unused_clr    = clr_count;
    assign illegal_count = '0;
`endif

endmodule

// File: doc/alu_decoder_pipe.md
# alu_decoder_pipe

Parametrised, elastic-pipelined ALU control decoder for the RV32I datapath. Accepts the main-decoder fields (ALUOp, funct3, op_5, funct7_5) under a valid/ready handshake, decodes the full RV32I ALU operation set, and delivers a registered ALUControl word after a configurable number of stages. Flags undecodable encodings and, optionally, counts them. It sits between the main decoder and the execute stage of the pipelined core.

## Interface
- CTRL_W, 4: ALUControl width. 4 gives the full RV32I set; 3 gives the legacy subset.
- DEPTH, 2: pipeline stages, 1..4.
- CNT_W, 16: illegal-counter width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- ALUOp  in  2  main-decoder ALU class.
- funct3  in  3  instruction funct3.
- op_5  in  1  opcode bit 5 (R-type vs I-type).
- funct7_5  in  1  instruction bit 30.
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accepts the output word.
- ALUControl  out  CTRL_W  decoded operation.
- illegal  out  1  output word came from an undecodable input.
- clr_count  in  1  synchronous clear of illegal_count.
- illegal_count  out  CNT_W  saturating count of illegal words delivered.

## Operation
- Encoding (CTRL_W=4): add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001. With CTRL_W=3 the codes are the low 3 bits of add/sub/and/or/slt.
- ALUOp 00 -> add. ALUOp 01 -> sub.
- ALUOp 10, by funct3:
  - 000 -> sub if op_5 & funct7_5, else add.
  - 001 -> sll.
  - 010 -> slt.
  - 011 -> sltu.
  - 100 -> xor.
  - 101 -> sra if funct7_5, else srl. op_5 is ignored here.
  - 110 -> or.
  - 111 -> and.
- ALUOp 11 -> illegal.
- With CTRL_W=3, xor, sltu, sll, srl and sra are illegal.
- An illegal word carries ALUControl=0 and illegal=1. It still flows through the pipeline like any other word.
- Decode is combinational on the input and is captured into stage 0. Stages 1..DEPTH-1 are plain elastic registers.
- Per-stage handshake:
  - ready[i] = !valid[i] | ready[i+1], with ready[DEPTH] = out_ready.
  - in_ready = ready[0], forced to 0 while reset is asserted.
  - The ready path is combinational across the stages.
- Counter: increments when out_valid & out_ready & illegal, and saturates at all-ones. clr_count wins over a same-cycle increment.

## Timing
- Reset asserted: every valid bit, ALUControl, illegal and illegal_count go to 0 immediately (asynchronous). in_ready is 0 while reset is asserted.
- Reset mid-operation: in-flight words are discarded. No word emerges after reset deasserts.
- Latency: a word accepted at edge N is visible on out_valid after edge N+DEPTH-1, i.e. DEPTH cycles of input-to-output delay, when there is no stall.
- Throughput: 1 word/cycle with out_ready held high.
- Stall: while out_valid & !out_ready, ALUControl and illegal hold stable.
- Capacity: the pipeline fills, then in_ready drops after DEPTH words are held. No word is lost or duplicated.
- Simultaneous accept and deliver on a full pipeline is permitted: in_ready stays 1 when out_ready is 1.

## Configuration
- ALUDEC_ILLEGAL_CNT_EN:
  - Defined: the illegal counter and clr_count logic are compiled in.
  - Undefined: illegal_count is tied to 0 and clr_count is ignored.
  - The illegal flag is always present either way.

## Test plan
- Sub latency (DEPTH=2, out_ready=1): reset, then push ALUOp=10, funct3=000, op_5=1, funct7_5=1 at edge N -> out_valid=1, ALUControl=0001 after edge N+1.
- Back-to-back stream: add (00), and (10/111), or (10/110), slt (10/010), sra (10/101, funct7_5=1), srli (10/101, op_5=0, funct7_5=0) -> 0000, 0010, 0011, 0101, 1001, 1000 on consecutive cycles.
- Backpressure: push 4 words with out_ready=0 for 5 cycles -> in_ready=0 after 2 words accepted, output held constant, all 4 delivered in order once out_ready=1.
- Illegal detection: ALUOp=11 -> illegal=1, ALUControl=0000, illegal_count=1. With CTRL_W=3, funct3=100 -> illegal=1, ALUControl=000.
- Counter behaviour (macro defined, CNT_W=4):
  - Deliver 17 illegal words -> illegal_count=15.
  - Assert clr_count in the same cycle as an illegal delivery -> illegal_count=0.
- Reset mid-flight: assert reset with 2 words in flight -> out_valid=0 immediately, no output after release, illegal_count=0.
